// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames (SYNC, ADDR, DATA_HI, DATA_LO, CHK) from a UART byte
// stream and issues a register write on a good checksum.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 17360
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_ready,
  input  logic [7:0]  byte_data,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        chk_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DHI,
    GET_DLO,
    GET_CHK
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              chk_err_q, chk_err_d;
  logic              to_err_q, to_err_d;
  logic              busy_q, busy_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      chk_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      chk_err_q <= chk_err_d;
      to_err_q  <= to_err_d;
      busy_q    <= busy_d;
    end
  end

  // Frame sequencing, checksum accumulation and inter-byte timeout
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    chk_err_d = 1'b0;
    to_err_d  = 1'b0;

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (byte_ready && (byte_data == SYNC_BYTE)) begin
        state_d = GET_ADDR;
        sum_d   = '0;
      end
    end else if (byte_ready) begin
      // An arriving byte always beats a coincident timeout expiry
      cnt_d = '0;
      case (state_q)
        GET_ADDR: begin
          addr_d  = byte_data;
          sum_d   = byte_data;
          state_d = GET_DHI;
        end
        GET_DHI: begin
          hi_d    = byte_data;
          sum_d   = sum_q + byte_data;
          state_d = GET_DLO;
        end
        GET_DLO: begin
          lo_d    = byte_data;
          sum_d   = sum_q + byte_data;
          state_d = GET_CHK;
        end
        GET_CHK: begin
          state_d = IDLE;
          if (byte_data == sum_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {hi_q, lo_q};
          end else begin
            chk_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d  = IDLE;
      to_err_d = 1'b1;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    busy_d = (state_d != IDLE);
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign chk_err     = chk_err_q;
  assign timeout_err = to_err_q;
  assign busy        = busy_q;

endmodule
